// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: FSM states, opcodes,
// PC control codes and the opcode-to-PC-control decode.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BZ   = 3'b010;
  localparam logic [2:0] OP_SKZ  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_LOAD = 2'b01;
  localparam logic [1:0] PC_INC1 = 2'b10;
  localparam logic [1:0] PC_INCN = 2'b11;

  // Width of the fetch-timeout counter (TIMEOUT range 1..15).
  localparam int TIMER_W = 4;

  // PC control code for an executed instruction; NOP and reserved opcodes step by one.
  function automatic logic [1:0] pc_code(input logic [2:0] op, input logic zero);
    case (op)
      OP_JMP:  pc_code = PC_LOAD;
      OP_BZ:   pc_code = zero ? PC_LOAD : PC_INC1;
      OP_SKZ:  pc_code = zero ? PC_INCN : PC_INC1;
      default: pc_code = PC_INC1;
    endcase
  endfunction

endpackage

// File: rtl/pc_sequencer_fetch_timer.sv
// Counts FETCH cycles spent waiting for imem_ack; expired flags the last
// allowed waiting cycle so the FSM can fault on it unless ack arrives.
module fetch_timer
  import pc_seq_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic restart,
  output logic expired
);

  logic [TIMER_W-1:0] count_q, count_d;

  // Next count: restart has priority over counting.
  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The current waiting cycle is the TIMEOUT-th one.
  assign expired = (count_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: fetches imem[pc], offers the word to the execute
// unit, then issues one PC control code per instruction.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] pc_val,
  output logic [1:0]   pc_cntrl,
  output logic [N-1:0] pc_load,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_data,
  output logic         exec_valid,
  output logic [W-1:0] exec_instr,
  input  logic         exec_ready,
  input  logic         zero,
  output logic         halted,
  output logic         fault
);

  state_e       state_q, state_d;
  logic [W-1:0] instr_q, instr_d;
  logic         fault_q, fault_d;
  logic [1:0]   pc_cntrl_q, pc_cntrl_d;
  logic [N-1:0] pc_load_q, pc_load_d;
  logic         t_en, t_restart, t_expired;
  logic [2:0]   op;
  logic [N-1:0] target;
  logic [1:0]   code;

  assign op     = instr_q[W-1 -: 3];
  assign target = instr_q[N-1:0];

  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .clr     (clr),
    .en      (t_en),
    .restart (t_restart),
    .expired (t_expired)
  );

  // Next-state logic. The PC code is computed on the EXEC acceptance edge
  // and registered, so it is presented for exactly the UPDATE cycle with no
  // combinational path from zero to pc_cntrl.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    fault_d    = fault_q;
    pc_cntrl_d = PC_HOLD;
    pc_load_d  = '0;
    t_en       = 1'b0;
    t_restart  = 1'b1;
    code       = pc_code(op, zero);
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        t_restart = 1'b0;
        if (imem_ack) begin
          instr_d   = imem_data;
          t_restart = 1'b1;
          state_d   = ST_EXEC;
        end else if (t_expired) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          t_en = 1'b1;
        end
      end
      ST_EXEC: begin
        if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (exec_ready) begin
          pc_cntrl_d = code;
          pc_load_d  = (code == PC_LOAD) ? target : '0;
          state_d    = ST_UPDATE;
        end
      end
      ST_UPDATE: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      fault_q    <= 1'b0;
      pc_cntrl_q <= PC_HOLD;
      pc_load_q  <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      fault_q    <= fault_d;
      pc_cntrl_q <= pc_cntrl_d;
      pc_load_q  <= pc_load_d;
    end
  end

  // Outputs decoded from registered state; a latched HALT opcode is never offered.
  assign imem_req   = (state_q == ST_FETCH);
  assign imem_addr  = imem_req ? pc_val : '0;
  assign exec_valid = (state_q == ST_EXEC) && (op != OP_HALT);
  assign exec_instr = exec_valid ? instr_q : '0;
  assign halted     = (state_q == ST_HALT);
  assign fault      = fault_q;
  assign pc_cntrl   = pc_cntrl_q;
  assign pc_load    = pc_load_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: an instruction-level model predicts the
// fetch address, executed word and PC control of every instruction.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] pc_val = '0;
  logic [1:0] pc_cntrl;
  logic [3:0] pc_load;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = '0;
  logic       exec_valid;
  logic [7:0] exec_instr;
  logic       exec_ready = 1'b0;
  logic       zero = 1'b0;
  logic       halted;
  logic       fault;

  always #5 clk = ~clk;

  pc_sequencer #(.N(4), .W(8), .TIMEOUT(15)) dut (
    .clk(clk), .clr(clr), .pc_val(pc_val), .pc_cntrl(pc_cntrl), .pc_load(pc_load),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .exec_valid(exec_valid), .exec_instr(exec_instr), .exec_ready(exec_ready),
    .zero(zero), .halted(halted), .fault(fault)
  );

  typedef struct {
    logic [3:0] pc;
    logic [7:0] ins;
    logic [1:0] cntrl;
    logic [3:0] load;
  } exp_t;

  exp_t       q[$];
  int         upd_times[$];
  logic [7:0] mem [16];
  bit         ztab [64];
  int         vectors = 0, miscompares = 0;
  int         ack_lo = 0, ack_hi = 0, rdy_lo = 0, rdy_hi = 0;
  int         n_pop = 0, cyc_cnt = 0;
  int         acnt = 0, adly = 0, rcnt = 0, rdly = 0;
  bit         exp_halt = 0;
  logic [3:0] halt_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // PC register model: inc = 2, cleared while clr is high.
  always @(posedge clk) begin
    if (clr) pc_val <= '0;
    else case (pc_cntrl)
      2'b01:   pc_val <= pc_load;
      2'b10:   pc_val <= pc_val + 4'd1;
      2'b11:   pc_val <= pc_val + 4'd2;
      default: pc_val <= pc_val;
    endcase
  end

  // Memory / execute responders with programmable delays, and zero flag per instruction.
  always @(posedge clk) begin
    #1;
    if (imem_req && !clr) begin
      if (acnt == adly) begin imem_ack = 1'b1; imem_data = mem[imem_addr]; end
      else begin imem_ack = 1'b0; imem_data = 8'($urandom); end
      acnt++;
    end else begin
      imem_ack = 1'b0; acnt = 0; adly = int'($urandom_range(ack_hi, ack_lo));
    end
    if (exec_valid && !clr) begin
      exec_ready = (rcnt == rdly); rcnt++;
    end else begin
      exec_ready = 1'b0; rcnt = 0; rdly = int'($urandom_range(rdy_hi, rdy_lo));
    end
    zero = ztab[n_pop];
  end

  // Monitor: checks every fetch, handshake and UPDATE against the scoreboard.
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_instr = '0;
  always @(negedge clk) begin
    cyc_cnt++;
    if (clr) begin
      prev_valid = 1'b0;
    end else begin
      if (imem_req) begin
        chk("imem_addr", 32'(imem_addr), 32'(pc_val));
        if (q.size() > 0) chk("fetch_pc", 32'(pc_val), 32'(q[0].pc));
      end
      if (prev_valid && !prev_ready) begin
        chk("valid_held", 32'(exec_valid), 32'd1);
        chk("instr_held", 32'(exec_instr), 32'(prev_instr));
      end
      if (exec_valid) begin
        chk("cntrl_hold_in_exec", 32'(pc_cntrl), 32'd0);
        if (exec_ready) begin
          if (q.size() > 0) chk("exec_instr", 32'(exec_instr), 32'(q[0].ins));
          else chk("unexpected_exec", 32'(exec_valid), 32'd0);
        end
      end
      if (pc_cntrl != 2'b00) begin
        upd_times.push_back(cyc_cnt);
        if (q.size() > 0) begin
          chk("pc_cntrl", 32'(pc_cntrl), 32'(q[0].cntrl));
          if (q[0].cntrl == 2'b01) chk("pc_load", 32'(pc_load), 32'(q[0].load));
          void'(q.pop_front());
          n_pop++;
        end else begin
          chk("unexpected_update", 32'(pc_cntrl), 32'd0);
        end
      end
      prev_valid = exec_valid; prev_ready = exec_ready; prev_instr = exec_instr;
    end
  end

  // Instruction-level reference: walk the program from pc 0.
  task automatic build_expect(input int max_n);
    logic [3:0] pc;
    logic [7:0] ins;
    exp_t e;
    pc = '0; exp_halt = 0;
    for (int k = 0; k < max_n; k++) begin
      ins = mem[pc];
      if (ins[7:5] == 3'b111) begin exp_halt = 1; halt_pc = pc; break; end
      e.pc = pc; e.ins = ins; e.load = '0; e.cntrl = 2'b10;
      if (ins[7:5] == 3'b001 || (ins[7:5] == 3'b010 && ztab[k])) begin
        e.cntrl = 2'b01; e.load = ins[3:0];
      end else if (ins[7:5] == 3'b011 && ztab[k]) begin
        e.cntrl = 2'b11;
      end
      q.push_back(e);
      if (e.cntrl == 2'b01) pc = e.load;
      else if (e.cntrl == 2'b11) pc = pc + 4'd2;
      else pc = pc + 4'd1;
    end
  endtask

  task automatic start(input int max_n);
    @(posedge clk); #2;
    clr = 1'b1; q.delete(); upd_times.delete(); n_pop = 0;
    build_expect(max_n);
    @(posedge clk); #2;
    @(negedge clk);
    chk("reset_outputs", 32'({pc_cntrl, pc_load, imem_req, imem_addr, exec_valid,
                              exec_instr, halted, fault}), 32'd0);
    @(posedge clk); #2;
    clr = 1'b0;
  endtask

  task automatic run_prog(input int max_n);
    int cyc;
    start(max_n);
    cyc = 0;
    while (q.size() > 0 && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("program_completed", 32'(q.size()), 32'd0);
    if (exp_halt) begin
      cyc = 0;
      while (!halted && cyc < 60) begin @(negedge clk); cyc++; end
      chk("halted", 32'(halted), 32'd1);
      repeat (3) @(negedge clk);
      chk("halt_pc", 32'(pc_val), 32'(halt_pc));
      chk("halt_no_fault", 32'(fault), 32'd0);
      chk("halt_outputs", 32'({imem_req, imem_addr, exec_valid, exec_instr, pc_cntrl, pc_load}), 32'd0);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    for (int i = 0; i < 64; i++) ztab[i] = 1'b0;
  endtask

  initial begin
    int n;
    int cyc;
    clear_prog();

    // NOP stream with immediate ack/ready: one UPDATE every 3 cycles.
    run_prog(6);
    for (int i = 1; i < upd_times.size(); i++)
      chk("nop_cadence", 32'(upd_times[i] - upd_times[i-1]), 32'd3);

    // JMP A with ack delayed 3 cycles, then HALT at A.
    clear_prog(); mem[0] = 8'h2A; mem[10] = 8'hE0;
    ack_lo = 3; ack_hi = 3;
    run_prog(10);
    ack_lo = 0; ack_hi = 0;

    // BZ taken, BZ not taken, JMP, SKZ taken, HALT.
    clear_prog();
    mem[0] = 8'h45; mem[5] = 8'h45; mem[6] = 8'h22; mem[2] = 8'h60; mem[4] = 8'hE0;
    ztab[0] = 1; ztab[1] = 0; ztab[2] = 0; ztab[3] = 1;
    run_prog(10);

    // exec_ready withheld 5 cycles on every instruction.
    clear_prog(); rdy_lo = 5; rdy_hi = 5;
    run_prog(4);
    rdy_lo = 0; rdy_hi = 0;

    // imem_ack never arrives: fault after 15 FETCH cycles.
    clear_prog(); ack_lo = 100; ack_hi = 100;
    start(0);
    n = 0; cyc = 0;
    while (!halted && cyc < 100) begin @(negedge clk); if (imem_req) n++; cyc++; end
    chk("timeout_fetch_cycles", 32'(n), 32'd15);
    chk("timeout_halted", 32'(halted), 32'd1);
    chk("timeout_fault", 32'(fault), 32'd1);
    repeat (4) @(negedge clk);
    chk("fault_sticky", 32'({fault, halted}), 32'b11);

    // Ack on the 15th FETCH cycle wins over the timeout.
    mem[0] = 8'hE0; ack_lo = 14; ack_hi = 14;
    start(0);
    n = 0; cyc = 0;
    while (!halted && cyc < 100) begin @(negedge clk); if (imem_req) n++; cyc++; end
    chk("late_ack_fetch_cycles", 32'(n), 32'd15);
    chk("late_ack_halted", 32'(halted), 32'd1);
    chk("late_ack_no_fault", 32'(fault), 32'd0);
    ack_lo = 0; ack_hi = 0;

    // clr pulsed mid-EXEC: outputs drop, one IDLE cycle, fresh fetch from 0.
    clear_prog(); rdy_lo = 50; rdy_hi = 50;
    start(5);
    cyc = 0;
    while (!exec_valid && cyc < 50) begin @(negedge clk); cyc++; end
    chk("exec_reached", 32'(exec_valid), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #2; clr = 1'b1; rdy_lo = 0; rdy_hi = 1;
    @(posedge clk); #2; clr = 1'b0;
    @(negedge clk);
    chk("clr_outputs", 32'({pc_cntrl, pc_load, imem_req, imem_addr, exec_valid,
                            exec_instr, halted, fault}), 32'd0);
    @(negedge clk);
    chk("clr_fresh_fetch", 32'({imem_req, imem_addr}), 32'h10);
    cyc = 0;
    while (q.size() > 0 && cyc < 500) begin @(negedge clk); cyc++; end
    chk("clr_program_completed", 32'(q.size()), 32'd0);

    // Randomized programs, delays and zero flags.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 16; i++) begin
        logic [2:0] op;
        op = 3'($urandom_range(0, 7));
        if (op == 3'b111 && $urandom_range(0, 3) != 0) op = 3'b000;
        mem[i] = {op, 5'($urandom)};
      end
      for (int i = 0; i < 64; i++) ztab[i] = 1'($urandom);
      ack_lo = 0; ack_hi = int'($urandom_range(0, 5));
      rdy_lo = 0; rdy_hi = int'($urandom_range(0, 6));
      run_prog(30);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
